// File: rtl/crc_pkg.sv
// Shared types and defaults for the bit-serial CRC engine.
package crc_pkg;

    // IDLE: waiting for a frame, SHIFT: absorbing frame bits, OUT: emitting the CRC.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        OUT   = 2'd2
    } crc_state_t;

    localparam logic [7:0] CRC_DEFAULT_POLY = 8'h44;
    localparam logic [7:0] CRC_DEFAULT_SEED = 8'hD8;

endpackage

// File: rtl/crc_lfsr_step.sv
// One absorb step of the right-shifting CRC LFSR (purely combinational).
// The feedback bit enters at the MSB and is XORed into every tap position
// selected by POLY below the MSB; POLY[WIDTH-1] has no effect.
module crc_lfsr_step #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = '0
) (
    input  logic [WIDTH-1:0] i_lfsr,
    input  logic             i_data,
    output logic [WIDTH-1:0] o_lfsr_nxt
);

    logic w_fb;

    assign w_fb = i_lfsr[0] ^ i_data;

    // Shift right by one, inject feedback at the top and at the tap positions.
    always_comb begin
        o_lfsr_nxt[WIDTH-1] = w_fb;
        for (int i = 0; i < int'(WIDTH) - 1; i++) begin
            o_lfsr_nxt[i] = i_lfsr[i+1] ^ (POLY[i] & w_fb);
        end
    end

endmodule

// File: rtl/crc_serial_engine.sv
// Bit-serial CRC generator: absorbs one DATA bit per clock while Active is
// high, then shifts the WIDTH-bit CRC out LSB-first with Valid asserted.
// The LFSR reloads SEED at the end of every frame.
// Optional macro CRC_CHECK_EN adds chk_mode/crc_err: in check mode the frame
// body carries data plus the received CRC and the end of frame produces a
// single Valid pulse with crc_err = (residue != 0) instead of the CRC stream.
// Handshake: a DATA bit is consumed on a rising edge only when Active=1 and
// in_ready=1; in_ready is low while the CRC is being emitted (state OUT).
module crc_serial_engine
    import crc_pkg::*;
#(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(CRC_DEFAULT_POLY),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(CRC_DEFAULT_SEED)
) (
    input  logic clk,
    input  logic RST,
    input  logic DATA,
    input  logic Active,
`ifdef CRC_CHECK_EN
    input  logic chk_mode,
    output logic crc_err,
`endif
    output logic in_ready,
    output logic CRC,
    output logic Valid,
    output logic frame_done
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    crc_state_t       r_state;
    crc_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_lfsr;
    logic [WIDTH-1:0] w_lfsr_nxt;
    logic [WIDTH-1:0] w_lfsr_step;
    logic [WIDTH-1:0] w_lfsr_shr;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             r_crc;
    logic             w_crc_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             w_chk;
`ifdef CRC_CHECK_EN
    logic             r_err;
    logic             w_err_nxt;

    assign w_chk = chk_mode;
`else
    assign w_chk = 1'b0;
`endif

    crc_lfsr_step #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_step (
        .i_lfsr     (r_lfsr),
        .i_data     (DATA),
        .o_lfsr_nxt (w_lfsr_step)
    );

    // Emitting the CRC drains the LFSR towards zero from the top.
    assign w_lfsr_shr = {1'b0, r_lfsr[WIDTH-1:1]};

    // Next-state, next-LFSR and next-output decode for the frame FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_lfsr_nxt  = r_lfsr;
        w_cnt_nxt   = r_cnt;
        w_crc_nxt   = 1'b0;
        w_valid_nxt = 1'b0;
        w_done_nxt  = 1'b0;
`ifdef CRC_CHECK_EN
        w_err_nxt   = r_err;
`endif
        case (r_state)
            IDLE: begin
                if (Active) begin
                    w_lfsr_nxt  = w_lfsr_step;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (Active) begin
                    w_lfsr_nxt = w_lfsr_step;
                end else if (w_chk) begin
                    // Check mode: one qualifier pulse, result in crc_err.
                    w_valid_nxt = 1'b1;
                    w_done_nxt  = 1'b1;
                    w_lfsr_nxt  = SEED;
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
`ifdef CRC_CHECK_EN
                    w_err_nxt   = |r_lfsr;
`endif
                end else begin
                    // The edge that sees Active fall already emits bit 0.
                    w_crc_nxt   = r_lfsr[0];
                    w_valid_nxt = 1'b1;
                    w_lfsr_nxt  = w_lfsr_shr;
                    w_cnt_nxt   = CW'(1);
                    w_state_nxt = OUT;
                end
            end
            OUT: begin
                w_crc_nxt   = r_lfsr[0];
                w_valid_nxt = 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_done_nxt  = 1'b1;
                    w_lfsr_nxt  = SEED;
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_lfsr_nxt = w_lfsr_shr;
                    w_cnt_nxt  = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_lfsr_nxt  = SEED;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State, LFSR, counter and output registers; reset discards any partial CRC.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
            r_lfsr  <= SEED;
            r_cnt   <= '0;
            r_crc   <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
`ifdef CRC_CHECK_EN
            r_err   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_lfsr  <= w_lfsr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_crc   <= w_crc_nxt;
            r_valid <= w_valid_nxt;
            r_done  <= w_done_nxt;
`ifdef CRC_CHECK_EN
            r_err   <= w_err_nxt;
`endif
        end
    end

    assign in_ready   = (r_state != OUT);
    assign CRC        = r_crc;
    assign Valid      = r_valid;
    assign frame_done = r_done;
`ifdef CRC_CHECK_EN
    assign crc_err    = r_err;
`endif

endmodule

// File: tb/tb_crc_serial_engine.sv
// Bench for crc_serial_engine: a default 8-bit instance and a 16-bit instance
// share the same stimulus; a frame-level reference model predicts every output
// cycle of both. Build with +define+CRC_CHECK_EN to exercise check mode.
module tb_crc_serial_engine;

  logic clk = 1'b0;
  logic RST;
  logic DATA;
  logic Active;
  logic chk_mode;

  logic crc8, valid8, done8, ir8;
  logic crc16, valid16, done16, ir16;
`ifdef CRC_CHECK_EN
  logic err8, err16;
`endif

  int tests = 0;
  int fails = 0;

  // Expected per-cycle output entries: {err_upd, err_val, done, crc}
  logic [3:0] exp_q8[$];
  logic [3:0] exp_q16[$];
  logic       bits8[$];
  logic       bits16[$];
  bit         in8, in16;
  logic       exp_err8, exp_err16;
  logic [31:0] cap8, cap16;
  int          vcnt16;

  // ---------------- clock / DUTs ----------------
  always #5 clk = ~clk;

  crc_serial_engine dut8 (
    .clk        (clk),
    .RST        (RST),
    .DATA       (DATA),
    .Active     (Active),
`ifdef CRC_CHECK_EN
    .chk_mode   (chk_mode),
    .crc_err    (err8),
`endif
    .in_ready   (ir8),
    .CRC        (crc8),
    .Valid      (valid8),
    .frame_done (done8)
  );

  crc_serial_engine #(
    .WIDTH (16),
    .POLY  (16'h0408),
    .SEED  (16'hFFFF)
  ) dut16 (
    .clk        (clk),
    .RST        (RST),
    .DATA       (DATA),
    .Active     (Active),
`ifdef CRC_CHECK_EN
    .chk_mode   (1'b0),
    .crc_err    (err16),
`endif
    .in_ready   (ir16),
    .CRC        (crc16),
    .Valid      (valid16),
    .frame_done (done16)
  );

  // ---------------- reference model ----------------
  // Reflected CRC of a bit list: per bit, shift right and XOR in the feedback
  // pattern (top bit plus taps below the top) when LSB^data is 1.
  function automatic logic [31:0] crc_ref(input int w, input logic [31:0] poly,
                                          input logic [31:0] seed,
                                          input logic [255:0] bits, input int n);
    logic [31:0] r;
    logic [31:0] k;
    k = (poly & ((32'd1 << (w - 1)) - 32'd1)) | (32'd1 << (w - 1));
    r = seed;
    for (int i = 0; i < n; i++) begin
      r = (r >> 1) ^ (((r[0] ^ bits[i]) != 1'b0) ? k : 32'd0);
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    exp_q8.delete();
    exp_q16.delete();
    bits8.delete();
    bits16.delete();
    in8 = 1'b0;
    in16 = 1'b0;
    exp_err8 = 1'b0;
    exp_err16 = 1'b0;
  endtask

  // Called at the negedge where the inputs for the next rising edge are set.
  task automatic model_step(input logic a, input logic d);
    logic [255:0] v;
    logic [31:0]  r;
    logic         ck;
`ifdef CRC_CHECK_EN
    ck = chk_mode;
`else
    ck = chk_mode & 1'b0;
`endif
    // 8-bit instance: a pending CRC stream means the next edge is an emit edge
    if (exp_q8.size() == 0) begin
      if (a) begin
        bits8.push_back(d);
        in8 = 1'b1;
      end else if (in8) begin
        v = '0;
        for (int i = 0; i < bits8.size(); i++) v[i] = bits8[i];
        r = crc_ref(8, 32'h44, 32'hD8, v, bits8.size());
        if (ck) exp_q8.push_back({1'b1, (r[7:0] != 8'd0), 1'b1, 1'b0});
        else for (int i = 0; i < 8; i++) exp_q8.push_back({2'b00, (i == 7), r[i]});
        bits8.delete();
        in8 = 1'b0;
      end
    end
    // 16-bit instance
    if (exp_q16.size() == 0) begin
      if (a) begin
        bits16.push_back(d);
        in16 = 1'b1;
      end else if (in16) begin
        v = '0;
        for (int i = 0; i < bits16.size(); i++) v[i] = bits16[i];
        r = crc_ref(16, 32'h0408, 32'hFFFF, v, bits16.size());
        for (int i = 0; i < 16; i++) exp_q16.push_back({2'b00, (i == 15), r[i]});
        bits16.delete();
        in16 = 1'b0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic a, input logic d, input logic c);
    @(negedge clk);
    Active = a;
    DATA = d;
    chk_mode = c;
    model_step(a, d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    RST = 1'b0;
    Active = 1'b0;
    DATA = 1'b0;
    chk_mode = 1'b0;
    clear_model();
    #1;
    chk("rst_valid8", valid8, 0);
    chk("rst_crc8", crc8, 0);
    chk("rst_done8", done8, 0);
    chk("rst_ready8", ir8, 1);
    chk("rst_valid16", valid16, 0);
    chk("rst_crc16", crc16, 0);
`ifdef CRC_CHECK_EN
    chk("rst_err8", err8, 0);
`endif
    repeat (2) @(negedge clk);
    RST = 1'b1;
  endtask

  task automatic drain_all();
    int n;
    n = 0;
    while ((exp_q8.size() != 0 || exp_q16.size() != 0) && n < 200) begin
      drive(1'b0, 1'b0, 1'b0);
      n++;
    end
    chk("drain8", exp_q8.size(), 0);
    chk("drain16", exp_q16.size(), 0);
  endtask

  // ---------------- compare process ----------------
  initial begin
    logic [3:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q8.size() != 0) begin
        e = exp_q8.pop_front();
        chk("valid8", valid8, 1);
        chk("crc8", crc8, e[0]);
        chk("done8", done8, e[1]);
        if (e[3]) exp_err8 = e[2];
        else cap8 = {24'd0, crc8, cap8[7:1]};
        chk("ready8", ir8, (exp_q8.size() == 0));
      end else begin
        chk("valid8_idle", valid8, 0);
        chk("crc8_idle", crc8, 0);
        chk("done8_idle", done8, 0);
        chk("ready8_idle", ir8, 1);
      end
      if (exp_q16.size() != 0) begin
        e = exp_q16.pop_front();
        chk("valid16", valid16, 1);
        chk("crc16", crc16, e[0]);
        chk("done16", done16, e[1]);
        cap16 = {16'd0, crc16, cap16[15:1]};
        chk("ready16", ir16, (exp_q16.size() == 0));
      end else begin
        chk("valid16_idle", valid16, 0);
        chk("crc16_idle", crc16, 0);
        chk("done16_idle", done16, 0);
        chk("ready16_idle", ir16, 1);
      end
      if (valid16) vcnt16++;
`ifdef CRC_CHECK_EN
      chk("err8", err8, exp_err8);
      chk("err16", err16, exp_err16);
`endif
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [255:0] v;
    logic [7:0]   cv;
    logic         a, d;
    RST = 1'b0;
    Active = 1'b0;
    DATA = 1'b0;
    chk_mode = 1'b0;
    cap8 = '0;
    cap16 = '0;
    vcnt16 = 0;
    clear_model();

    // Pin the model against hand-computed values
    v = '0;
    chk("pin_bit0", crc_ref(8, 32'h44, 32'hD8, v, 1), 32'h6C);
    v[0] = 1'b1;
    chk("pin_bit1", crc_ref(8, 32'h44, 32'hD8, v, 1), 32'hA8);
    v[8:1] = 8'hA8;
    chk("pin_resid", crc_ref(8, 32'h44, 32'hD8, v, 9), 32'h0);

    do_reset();

    // Single bit 0 -> 0x6C
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drain_all();
    chk("t1_crc", cap8, 32'h6C);

    // Single bit 1 -> 0xA8, then an immediate identical frame
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    repeat (7) drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    chk("t2_crc_a", cap8, 32'hA8);
    drive(1'b0, 1'b0, 1'b0);
    drain_all();
    chk("t2_crc_b", cap8, 32'hA8);

    // Active held high through OUT: bits dropped, next frame starts from SEED
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    repeat (7) drive(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    chk("t3_crc", cap8, 32'h6C);
    drive(1'b0, 1'b0, 1'b0);
    drain_all();
    chk("t3_next", cap8, 32'hA8);

    // Reset on the 3rd CRC bit
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    RST = 1'b0;
    clear_model();
    #1;
    chk("t4_valid", valid8, 0);
    chk("t4_crc", crc8, 0);
    chk("t4_ready", ir8, 1);
    @(negedge clk);
    @(negedge clk);
    RST = 1'b1;
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drain_all();
    chk("t4_after", cap8, 32'h6C);

`ifdef CRC_CHECK_EN
    // Check mode: bit 1 then 0xA8 LSB-first is a clean frame
    cv = 8'hA8;
    drive(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) drive(1'b1, cv[i], 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    drain_all();
    chk("t5_ok", err8, 0);
    cv = 8'hA8 ^ 8'h08;
    drive(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) drive(1'b1, cv[i], 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    drain_all();
    chk("t5_bad", err8, 1);
`else
    cv = 8'h00;
`endif

    // 16-bit: 32 random bits
    do_reset();
    v = '0;
    for (int i = 0; i < 32; i++) begin
      d = 1'($urandom_range(0, 1));
      v[i] = d;
      drive(1'b1, d, 1'b0);
    end
    vcnt16 = 0;
    drive(1'b0, 1'b0, 1'b0);
    drain_all();
    chk("t6_crc16", cap16, crc_ref(16, 32'h0408, 32'hFFFF, v, 32));
    chk("t6_vcnt", vcnt16, 16);

    // Random traffic, including stalls and back-to-back frames
    for (int n = 0; n < 600; n++) begin
      a = ($urandom_range(0, 3) != 0);
      if (bits8.size() >= 200 || bits16.size() >= 200) a = 1'b0;
      d = 1'($urandom_range(0, 1));
`ifdef CRC_CHECK_EN
      drive(a, d, 1'($urandom_range(0, 1)));
`else
      drive(a, d, 1'b0);
`endif
    end
    drive(1'b0, 1'b0, 1'b0);
    drain_all();
    repeat (3) drive(1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
